image_blitter: RTL and testbench

//  Parametrised full-frame image blitter; successor to the single-image background drawers.
//  - Scans every pixel of one of NUM_IMG pre-stored images, row-major.
//  - Reads each pixel's colour from external synchronous ROMs.
//  - Emits aligned x/y/colour/plot to the VGA adapter.
//  - Provides a start/busy/done handshake, so the game FSM knows when a frame write is complete.

---
 rtl/image_blitter_if.sv | 38 +++
 rtl/image_blitter.sv | 124 ++++++++++++
 tb/tb_image_blitter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/image_blitter_if.sv
// image_blitter_if: control, ROM and VGA-side signals of the image blitter
// Groups the blit handshake (start/img_sel/busy/done), the shared ROM port
// (rom_addr/rom_q) and the pixel stream (x/y/colour/plot).
// slave modport: the blitter itself; master modport: the surrounding system
// (game FSM, ROMs, VGA adapter). With TRANSPARENT_EN defined the interface
// also carries key_colour/key_on for colour-keyed plotting.
interface image_blitter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int NUM_IMG  = 4,
  parameter int SEL_W    = 2,
  parameter int ADDR_W   = 15
);
  logic                        start;
  logic [SEL_W-1:0]            img_sel;
  logic [ADDR_W-1:0]           rom_addr;
  logic [NUM_IMG*COLOUR_W-1:0] rom_q;
  logic [X_W-1:0]              x;
  logic [Y_W-1:0]              y;
  logic [COLOUR_W-1:0]         colour;
  logic                        plot;
  logic                        busy;
  logic                        done;
`ifdef TRANSPARENT_EN
  logic [COLOUR_W-1:0]         key_colour;
  logic                        key_on;
  modport slave (input start, img_sel, rom_q, key_colour, key_on,
                 output rom_addr, x, y, colour, plot, busy, done);
  modport master (output start, img_sel, rom_q, key_colour, key_on,
                  input rom_addr, x, y, colour, plot, busy, done);
`else
  modport slave (input start, img_sel, rom_q,
                 output rom_addr, x, y, colour, plot, busy, done);
  modport master (output start, img_sel, rom_q,
                  input rom_addr, x, y, colour, plot, busy, done);
`endif
endinterface

// File: rtl/image_blitter.sv
// image_blitter: full-frame blitter scanning one of NUM_IMG ROM images row-major to a VGA adapter
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset    - synchronous, active-high
//   bus      - image_blitter_if.slave: start/img_sel in, rom_addr out,
//              rom_q in, x/y/colour/plot out, busy/done out
// Optional feature macro TRANSPARENT_EN: when defined, pixels equal to
// bus.key_colour are not plotted while bus.key_on is high.
module image_blitter #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int NUM_IMG  = 4,
  parameter int SEL_W    = 2,
  parameter int ADDR_W   = 15,
  parameter int ROM_LAT  = 1
) (
  input logic             CLOCK_50,
  input logic             reset,
  image_blitter_if.slave  bus
);
  localparam int CW = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [X_W-1:0]      sx_q;
  logic [Y_W-1:0]      sy_q;
  logic [CW-1:0]       dcnt_q;
  logic [X_W-1:0]      dx_q [ROM_LAT];
  logic [Y_W-1:0]      dy_q [ROM_LAT];
  logic [ROM_LAT-1:0]  dv_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q, busy_q, done_q;
  logic                plot_d, busy_d, done_d;
  logic                last, row_end, accept;
  logic [COLOUR_W-1:0] pix [NUM_IMG];
  logic [COLOUR_W-1:0] pix_sel;
  for (genvar i = 0; i < NUM_IMG; i++) begin : g_pix
    assign pix[i] = bus.rom_q[i*COLOUR_W +: COLOUR_W];
  end
  assign row_end = sx_q == X_W'(H_RES - 1);
  assign last    = row_end && sy_q == Y_W'(V_RES - 1);
  assign accept  = state_q == IDLE && bus.start;
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (bus.start ? SCAN : IDLE) :
              state_q == SCAN  ? (last ? DRAIN : SCAN) :
              state_q == DRAIN ? (dcnt_q == CW'(ROM_LAT - 1) ? FINISH : DRAIN) :
                                 IDLE;
  end
  always_comb begin
    busy_d  = state_d != IDLE;
    done_d  = state_q == FINISH;
    pix_sel = pix[sel_q];
`ifdef TRANSPARENT_EN
    plot_d  = dv_q[ROM_LAT-1] && !(bus.key_on && pix_sel == bus.key_colour);
`else
    plot_d  = dv_q[ROM_LAT-1];
`endif
  end
  // Scan counters and a ROM_LAT-deep delay line that lines x/y/valid up with
  // rom_q; the output stage then registers everything together.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sel_q    <= '0;
      addr_q   <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      dcnt_q   <= '0;
      dv_q     <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (accept) begin
        sel_q  <= 32'(bus.img_sel) < NUM_IMG ? bus.img_sel : '0;
        addr_q <= '0;
        sx_q   <= '0;
        sy_q   <= '0;
      end else if (state_q == SCAN && !last) begin
        addr_q <= addr_q + 1'b1;
        sx_q   <= row_end ? '0 : sx_q + 1'b1;
        sy_q   <= row_end ? sy_q + 1'b1 : sy_q;
      end
      dcnt_q  <= state_q == DRAIN ? dcnt_q + 1'b1 : '0;
      dv_q[0] <= state_q == SCAN;
      dx_q[0] <= sx_q;
      dy_q[0] <= sy_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        dv_q[i] <= dv_q[i-1];
        dx_q[i] <= dx_q[i-1];
        dy_q[i] <= dy_q[i-1];
      end
      x_q      <= dx_q[ROM_LAT-1];
      y_q      <= dy_q[ROM_LAT-1];
      colour_q <= pix_sel;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign bus.rom_addr = addr_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_image_blitter.sv
// tb_image_blitter: scoreboard bench running ROM_LAT=1 and ROM_LAT=2 blitters side by side
module tb_image_blitter;
  localparam int H = 160;
  localparam int V = 120;
  localparam int N = H * V;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] img_sel = 2'd0;
  always #5 clk = ~clk;
  image_blitter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .NUM_IMG(4), .SEL_W(2), .ADDR_W(15)) bus_a ();
  image_blitter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .NUM_IMG(4), .SEL_W(2), .ADDR_W(15)) bus_b ();
  image_blitter #(.ROM_LAT(1)) dut_a (.CLOCK_50(clk), .reset(rst), .bus(bus_a));
  image_blitter #(.ROM_LAT(2)) dut_b (.CLOCK_50(clk), .reset(rst), .bus(bus_b));
  function automatic logic [2:0] pat(input int a, input int i);
    return 3'(((a & 7) ^ ((a >> 7) & 7)) + i);
  endfunction
  logic [14:0] ra1, rb1, rb2;
  always @(posedge clk) begin
    ra1 <= bus_a.rom_addr;
    rb1 <= bus_b.rom_addr;
    rb2 <= rb1;
  end
  assign bus_a.start   = start;
  assign bus_b.start   = start;
  assign bus_a.img_sel = img_sel;
  assign bus_b.img_sel = img_sel;
  assign bus_a.rom_q = {pat(int'(ra1), 3), pat(int'(ra1), 2), pat(int'(ra1), 1), pat(int'(ra1), 0)};
  assign bus_b.rom_q = {pat(int'(rb2), 3), pat(int'(rb2), 2), pat(int'(rb2), 1), pat(int'(rb2), 0)};
`ifdef TRANSPARENT_EN
  assign bus_a.key_on     = 1'b0;
  assign bus_b.key_on     = 1'b0;
  assign bus_a.key_colour = 3'd0;
  assign bus_b.key_colour = 3'd0;
`endif
  logic       pl [2];
  logic       dn [2];
  logic       bs [2];
  logic [7:0] xs [2];
  logic [6:0] ys [2];
  logic [2:0] cs [2];
  assign pl[0] = bus_a.plot;   assign pl[1] = bus_b.plot;
  assign dn[0] = bus_a.done;   assign dn[1] = bus_b.done;
  assign bs[0] = bus_a.busy;   assign bs[1] = bus_b.busy;
  assign xs[0] = bus_a.x;      assign xs[1] = bus_b.x;
  assign ys[0] = bus_a.y;      assign ys[1] = bus_b.y;
  assign cs[0] = bus_a.colour; assign cs[1] = bus_b.colour;
  int checks = 0;
  int errors = 0;
  logic [17:0] expq [$];
  int  ptr [2] = '{0, 0};
  int  pcnt [2] = '{0, 0};
  int  dcnt [2] = '{0, 0};
  logic prev [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 2; g++) begin
        if (pl[g]) begin
          checks++;
          if (ptr[g] >= expq.size()) begin
            errors++;
            $display("FAIL extra_plot dut%0d got (%0d,%0d,%0d) expected no plot", g, xs[g], ys[g], cs[g]);
          end else if ({xs[g], ys[g], cs[g]} !== expq[ptr[g]]) begin
            errors++;
            $display("FAIL pixel dut%0d idx %0d got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", g, ptr[g],
                     xs[g], ys[g], cs[g], expq[ptr[g]][17:10], expq[ptr[g]][9:3], expq[ptr[g]][2:0]);
          end
          ptr[g]++;
          pcnt[g]++;
        end
        if (dn[g]) begin
          checks++;
          dcnt[g]++;
          if (!prev[g] || pl[g] || pcnt[g] != N) begin
            errors++;
            $display("FAIL done_timing dut%0d got prev_plot=%0d plot=%0d plots=%0d expected 1/0/%0d",
                     g, prev[g], pl[g], pcnt[g], N);
          end
          pcnt[g] = 0;
        end
        prev[g] = pl[g];
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic go(input logic [1:0] sel);
    expq.delete();
    for (int n = 0; n < N; n++) expq.push_back({8'(n % H), 7'(n / H), pat(n, int'(sel))});
    for (int g = 0; g < 2; g++) begin
      ptr[g]  = 0;
      pcnt[g] = 0;
    end
    start   = 1'b1;
    img_sel = sel;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int target);
    int n = 0;
    while (dcnt[1] < target && n < N + 100) begin
      @(posedge clk);
      n++;
    end
    chk("done_b_count", dcnt[1], target);
    chk("done_a_count", dcnt[0], target);
    chk("all_pixels_b", ptr[1], N);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_plot"}, {30'd0, bus_b.plot, bus_a.plot}, 0);
    chk({tag, "_busy"}, {30'd0, bus_b.busy, bus_a.busy}, 0);
    chk({tag, "_done"}, {30'd0, bus_b.done, bus_a.done}, 0);
    chk({tag, "_xy"}, {bus_a.x, bus_a.y, bus_b.x, bus_b.y}, 0);
    chk({tag, "_colour"}, {bus_a.colour, bus_b.colour}, 0);
    chk({tag, "_rom_addr"}, {bus_a.rom_addr, bus_b.rom_addr}, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 go(2'd2);
    @(negedge clk);
    chk("busy_after_start", {30'd0, bus_b.busy, bus_a.busy}, 3);
    chk("plot_a_cycle1", bus_a.plot, 0);
    @(negedge clk);
    chk("plot_a_cycle2", bus_a.plot, 0);
    @(negedge clk);
    chk("plot_a_first", bus_a.plot, 1);
    chk("plot_b_not_yet", bus_b.plot, 0);
    chk("first_px_a", {bus_a.x, bus_a.y, bus_a.colour}, {8'd0, 7'd0, pat(0, 2)});
    @(negedge clk);
    chk("plot_b_first", bus_b.plot, 1);
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("idle_busy", {30'd0, bus_b.busy, bus_a.busy}, 0);
    @(posedge clk);
    #1 go(2'd1);
    for (int k = 0; k < 6; k++) begin
      repeat (3000) @(posedge clk);
      #1 start = 1'b1;
      img_sel = 2'(k);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("busy_mid_blit", {30'd0, bus_b.busy, bus_a.busy}, 3);
    end
    wait_done(2);
    @(posedge clk);
    #1 go(2'd3);
    for (int n = 0; n < N && pcnt[0] < 5000; n++) @(posedge clk);
    chk("reached_5000", pcnt[0], 5000);
    #1 rst = 1'b1;
    @(posedge clk);
    expq.delete();
    for (int g = 0; g < 2; g++) begin
      ptr[g]  = 0;
      pcnt[g] = 0;
      prev[g] = 1'b0;
    end
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", dcnt[0] + dcnt[1], 4);
    @(posedge clk);
    #1 go(2'd0);
    wait_done(3);
    repeat (5) @(negedge clk);
    chk("final_done_a", dcnt[0], 3);
    chk("final_done_b", dcnt[1], 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
